stepper_phase_monitor: RTL

- Reads the 4-bit coil phase bus driven to the door-lock stepper and decodes it back into step events, direction and absolute position.
- Tracks door state and flags illegal phase sequences for the security controller.
- Sits beside the stepper driver, receives the same phase bus, and reports to the alarm/status logic.

---
 rtl/stepper_phase_monitor_if.sv | 40 ++++
 rtl/stepper_phase_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/stepper_phase_monitor_if.sv
// Interface bundle for the stepper phase monitor: the observed phase bus and
// clear request going in, the decoded step/door/alarm status coming out.
// The driver/bench side uses the master modport, the monitor uses slave.
interface stepper_phase_monitor_if #(
    parameter int POS_W = 12
);
    logic [3:0]       phase_in;
    logic             clear_pos;
    logic             step_pulse;
    logic             step_dir;
    logic [POS_W-1:0] position;
    logic [1:0]       door_state;
    logic             illegal;
    logic [7:0]       err_count;
    logic             stall;

    modport master (
        output phase_in,
        output clear_pos,
        input  step_pulse,
        input  step_dir,
        input  position,
        input  door_state,
        input  illegal,
        input  err_count,
        input  stall
    );

    modport slave (
        input  phase_in,
        input  clear_pos,
        output step_pulse,
        output step_dir,
        output position,
        output door_state,
        output illegal,
        output err_count,
        output stall
    );
endinterface

// File: rtl/stepper_phase_monitor.sv
// Stepper phase monitor: decodes the 4-bit one-hot coil phase bus of the
// door-lock stepper into step events, direction, absolute position and door
// state, and flags illegal phase sequences.
// Optional stall detection is built only when STALL_DETECT_EN is defined;
// otherwise the stall output is tied low.
module stepper_phase_monitor #(
    parameter int POS_W        = 12,
    parameter int OPEN_STEPS   = 100,
    parameter int STALL_CYCLES = 40000
) (
    input logic                   clk,
    input logic                   reset,
    stepper_phase_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } door_t;

    localparam logic [3:0] PHASE_RESET = 4'b1000;

    if (STALL_CYCLES < 1) begin : g_bad_stall_cycles
        $error("STALL_CYCLES must be at least 1");
    end

    door_t            state;
    door_t            state_next;
    logic [3:0]       sync1;
    logic [3:0]       cur;
    logic [3:0]       cur_d;
    logic [3:0]       prev;
    logic             fwd;
    logic             rev;
    logic             bad;
    logic             resync;
    logic             onehot;
    logic             underrun;
    logic             step_evt;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_step;
    logic             step_pulse_q;
    logic             step_dir_q;
    logic             illegal_q;
    logic [7:0]       err_q;

    // Two-flop synchronizer for the asynchronous phase bus, plus a copy of the
    // previous synchronized sample so each new pattern is judged exactly once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= PHASE_RESET;
            cur   <= PHASE_RESET;
            cur_d <= PHASE_RESET;
        end else begin
            sync1 <= bus.phase_in;
            cur   <= sync1;
            cur_d <= cur;
        end
    end

    // Classify a newly arrived pattern against the last accepted phase.
    always_comb begin
        fwd    = 1'b0;
        rev    = 1'b0;
        bad    = 1'b0;
        resync = 1'b0;
        onehot = (cur != 4'b0000) && ((cur & (cur - 4'd1)) == 4'b0000);
        if ((cur != cur_d) && (cur != prev) && (cur != 4'b0000)) begin
            if (cur == {prev[0], prev[3:1]}) begin
                fwd = 1'b1;
            end else if (cur == {prev[2:0], prev[3]}) begin
                rev = 1'b1;
            end else begin
                bad    = 1'b1;
                resync = onehot;
            end
        end
        step_evt = fwd || rev;
        underrun = rev && (state == CLOSED);
    end

    // Position after the decoded step, before any clear request is applied.
    always_comb begin
        pos_step = pos_q;
        if (fwd) begin
            pos_step = pos_q + POS_W'(1);
        end else if (rev) begin
            pos_step = pos_q - POS_W'(1);
        end
    end

    // Door state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLOSED;
        end else begin
            state <= state_next;
        end
    end

    // Door state transitions driven by decoded steps and the clear request.
    always_comb begin
        state_next = state;
        if (bus.clear_pos) begin
            state_next = CLOSED;
        end else begin
            case (state)
                CLOSED: begin
                    if (fwd) state_next = OPENING;
                end
                OPENING: begin
                    if (fwd && (pos_step == POS_W'(OPEN_STEPS))) state_next = OPEN;
                    else if (rev) state_next = CLOSING;
                end
                OPEN: begin
                    if (rev) state_next = CLOSING;
                end
                CLOSING: begin
                    if (rev && (pos_step == '0)) state_next = CLOSED;
                    else if (fwd) state_next = OPENING;
                end
                default: state_next = CLOSED;
            endcase
        end
    end

    // Door state output is the state encoding itself.
    always_comb begin
        bus.door_state = state;
    end

    // Last accepted phase: follows legal steps and skipped-phase resyncs only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= PHASE_RESET;
        end else if (step_evt || resync) begin
            prev <= cur;
        end
    end

    // Step, direction, position and alarm outputs, all registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_pulse_q <= 1'b0;
            step_dir_q   <= 1'b1;
            illegal_q    <= 1'b0;
            pos_q        <= '0;
            err_q        <= 8'd0;
        end else begin
            step_pulse_q <= step_evt;
            illegal_q    <= bad || underrun;
            if (fwd) begin
                step_dir_q <= 1'b1;
            end else if (rev) begin
                step_dir_q <= 1'b0;
            end
            pos_q <= bus.clear_pos ? '0 : pos_step;
            if ((bad || underrun) && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign bus.step_pulse = step_pulse_q;
    assign bus.step_dir   = step_dir_q;
    assign bus.illegal    = illegal_q;
    assign bus.position   = pos_q;
    assign bus.err_count  = err_q;

`ifdef STALL_DETECT_EN
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               stall_q;
    logic               moving;

    assign moving = (state == OPENING) || (state == CLOSING);

    // Count idle cycles while the door is in motion; raise stall at the limit
    // and hold it until the next step or clear request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            stall_q   <= 1'b0;
        end else if (step_evt || bus.clear_pos || !moving) begin
            stall_cnt <= '0;
            if (step_evt || bus.clear_pos) begin
                stall_q <= 1'b0;
            end
        end else if (stall_cnt != STALL_W'(STALL_CYCLES)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
            if (stall_cnt == STALL_W'(STALL_CYCLES - 1)) begin
                stall_q <= 1'b1;
            end
        end
    end

    assign bus.stall = stall_q;
`else
    assign bus.stall = 1'b0;
`endif
endmodule
